// File: rtl/tcp_path_arbiter_if.sv
// Bundle of the two requester ports, the merged output port and the packet
// counters. The arbiter uses the slave view; the traffic source uses master.
interface tcp_path_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data_0;
    logic [DATA_WIDTH-1:0] in_data_1;
    logic [CTRL_WIDTH-1:0] in_ctrl_0;
    logic [CTRL_WIDTH-1:0] in_ctrl_1;
    logic                  in_wr_0;
    logic                  in_wr_1;
    logic                  in_rdy_0;
    logic                  in_rdy_1;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;
    logic [31:0]           pkt_cnt_0;
    logic [31:0]           pkt_cnt_1;

    modport slave (
        input  in_data_0, in_data_1, in_ctrl_0, in_ctrl_1, in_wr_0, in_wr_1, out_rdy,
        output in_rdy_0, in_rdy_1, out_data, out_ctrl, out_wr, pkt_cnt_0, pkt_cnt_1
    );

    modport master (
        output in_data_0, in_data_1, in_ctrl_0, in_ctrl_1, in_wr_0, in_wr_1, out_rdy,
        input  in_rdy_0, in_rdy_1, out_data, out_ctrl, out_wr, pkt_cnt_0, pkt_cnt_1
    );
endinterface

// File: rtl/tcp_path_arbiter.sv
// Two-port packet arbiter: per-port fallthrough FIFOs feeding one output,
// round-robin between whole packets with one idle cycle between them.
module tcp_path_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    tcp_path_arbiter_if.slave    bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   DEPTH_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_BITS:0]   NF_LEVEL  = DEPTH_CNT - 1'b1;
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE   = 1;
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE   = 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

    logic [DATA_WIDTH-1:0]      data_mem [2][DEPTH];
    logic [CTRL_WIDTH-1:0]      ctrl_mem [2][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr   [2];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr   [2];
    logic [FIFO_DEPTH_BITS:0]   count    [2];
    logic [DATA_WIDTH-1:0]      in_data  [2];
    logic [CTRL_WIDTH-1:0]      in_ctrl  [2];
    logic [1:0]                 in_wr;
    logic [1:0]                 empty;
    logic [1:0]                 full;
    logic [1:0]                 nearly_full;
    logic [1:0]                 wr_en;
    logic [1:0]                 rd_en;

    logic [1:0]            state;
    logic                  grant;
    logic                  last;
    logic [31:0]           cnt_0;
    logic [31:0]           cnt_1;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign in_data[0] = bus.in_data_0;
    assign in_data[1] = bus.in_data_1;
    assign in_ctrl[0] = bus.in_ctrl_0;
    assign in_ctrl[1] = bus.in_ctrl_1;
    assign in_wr      = {bus.in_wr_1, bus.in_wr_0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i]       = (count[i] == '0);
            full[i]        = (count[i] == DEPTH_CNT);
            nearly_full[i] = (count[i] >= NF_LEVEL);
        end
    end

    // Reset gates the transfer so out_wr is low in the reset cycle itself.
    assign transfer  = !reset && (state != IDLE) && !empty[grant] && bus.out_rdy;
    assign head_data = data_mem[grant][rd_ptr[grant]];
    assign head_ctrl = ctrl_mem[grant][rd_ptr[grant]];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_en[i] = transfer && (grant == 1'(i));
            wr_en[i] = in_wr[i] && (!full[i] || rd_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                data_mem[i][wr_ptr[i]] <= in_data[i];
                ctrl_mem[i][wr_ptr[i]] <= in_ctrl[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                case ({wr_en[i], rd_en[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // last starts at 1 so port 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty[0] && !empty[1]) begin
                        grant <= ~last;
                        state <= HDR;
                    end else if (!empty[0]) begin
                        grant <= 1'b0;
                        state <= HDR;
                    end else if (!empty[1]) begin
                        grant <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (transfer && head_ctrl == '0) state <= BODY;
                end
                BODY: begin
                    if (transfer && head_ctrl != '0) begin
                        if (grant) cnt_1 <= cnt_1 + 32'd1;
                        else       cnt_0 <= cnt_0 + 32'd1;
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy_0  = !nearly_full[0];
    assign bus.in_rdy_1  = !nearly_full[1];
    assign bus.out_wr    = transfer;
    assign bus.out_data  = head_data;
    assign bus.out_ctrl  = head_ctrl;
    assign bus.pkt_cnt_0 = cnt_0;
    assign bus.pkt_cnt_1 = cnt_1;
endmodule

// File: tb/tb_tcp_path_arbiter.sv
// Self-checking bench for tcp_path_arbiter: queue-based packet model of both
// ports plus directed scenarios and a randomized traffic run.
module tb_tcp_path_arbiter;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tcp_path_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    tcp_path_arbiter #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .FIFO_DEPTH_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    word_t tx0[$];
    word_t tx1[$];
    int    rdy_mode = 0;

    // Model: words buffered per port, packet owner and round-robin memory.
    word_t       m_q0[$];
    word_t       m_q1[$];
    bit          busy    = 0;
    bit          owner   = 0;
    bit          seen    = 0;
    bit          m_last  = 1;
    logic [31:0] m_cnt0  = 0;
    logic [31:0] m_cnt1  = 0;
    int          out_words = 0;
    int          pkt_order[$];

    function automatic word_t mk(input logic [CW-1:0] c);
        word_t w;
        w.ctrl = c;
        w.data = {32'($urandom), 32'($urandom)};
        return w;
    endfunction

    function automatic void push_tx(input bit port, input word_t w);
        if (port) tx1.push_back(w);
        else      tx0.push_back(w);
    endfunction

    function automatic void make_pkt(input bit port, input int nhdr, input int npay);
        for (int i = 0; i < nhdr; i++) push_tx(port, mk(CW'($urandom_range(1, 255))));
        for (int i = 0; i < npay; i++) push_tx(port, mk('0));
        push_tx(port, mk(CW'($urandom_range(1, 255))));
    endfunction

    // Source: honours in_rdy, one word per cycle per port.
    initial begin
        bus.in_wr_0 = 0; bus.in_wr_1 = 0;
        bus.in_data_0 = '0; bus.in_data_1 = '0;
        bus.in_ctrl_0 = '0; bus.in_ctrl_1 = '0;
        bus.out_rdy = 1;
        forever begin
            @(posedge clk); #1;
            if (tx0.size() > 0 && bus.in_rdy_0 === 1'b1) begin
                {bus.in_ctrl_0, bus.in_data_0} = tx0.pop_front();
                bus.in_wr_0 = 1;
            end else bus.in_wr_0 = 0;
            if (tx1.size() > 0 && bus.in_rdy_1 === 1'b1) begin
                {bus.in_ctrl_1, bus.in_data_1} = tx1.pop_front();
                bus.in_wr_1 = 1;
            end else bus.in_wr_1 = 0;
            case (rdy_mode)
                0:       bus.out_rdy = 1;
                1:       bus.out_rdy = 0;
                2:       bus.out_rdy = ~bus.out_rdy;
                default: bus.out_rdy = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Reference model evaluated once per cycle, away from the clock edge.
    initial begin
        word_t w;
        bit    exp_wr;
        forever begin
            @(negedge clk);
            if (reset) begin
                checks++;
                if (bus.out_wr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL out_wr_in_reset: got %0b expected 0", bus.out_wr);
                end
                m_q0.delete(); m_q1.delete();
                busy = 0; seen = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
            end else begin
                checks++;
                if (bus.in_rdy_0 !== (m_q0.size() < DEPTH - 1)) begin
                    errors++;
                    $display("[TB] FAIL in_rdy_0: got %0b with %0d buffered", bus.in_rdy_0, m_q0.size());
                end
                checks++;
                if (bus.in_rdy_1 !== (m_q1.size() < DEPTH - 1)) begin
                    errors++;
                    $display("[TB] FAIL in_rdy_1: got %0b with %0d buffered", bus.in_rdy_1, m_q1.size());
                end
                checks++;
                if (bus.pkt_cnt_0 !== m_cnt0 || bus.pkt_cnt_1 !== m_cnt1) begin
                    errors++;
                    $display("[TB] FAIL pkt_cnt: got %0h/%0h expected %0h/%0h",
                             bus.pkt_cnt_0, bus.pkt_cnt_1, m_cnt0, m_cnt1);
                end
                exp_wr = busy && bus.out_rdy &&
                         ((owner ? m_q1.size() : m_q0.size()) > 0);
                checks++;
                if (bus.out_wr !== exp_wr) begin
                    errors++;
                    $display("[TB] FAIL out_wr: got %0b expected %0b", bus.out_wr, exp_wr);
                end
                if (exp_wr) begin
                    if (owner) w = m_q1.pop_front();
                    else       w = m_q0.pop_front();
                    out_words++;
                    checks++;
                    if ({bus.out_ctrl, bus.out_data} !== w) begin
                        errors++;
                        $display("[TB] FAIL out_word: got %0h:%0h expected %0h:%0h",
                                 bus.out_ctrl, bus.out_data, w.ctrl, w.data);
                    end
                    if (w.ctrl != '0 && seen) begin
                        if (owner) m_cnt1 = m_cnt1 + 1;
                        else       m_cnt0 = m_cnt0 + 1;
                        m_last = owner;
                        busy   = 0;
                        pkt_order.push_back(int'(owner));
                    end else if (w.ctrl == '0) begin
                        seen = 1;
                    end
                end else if (!busy) begin
                    if (m_q0.size() > 0 && m_q1.size() > 0) begin
                        owner = !m_last; busy = 1; seen = 0;
                    end else if (m_q0.size() > 0) begin
                        owner = 0; busy = 1; seen = 0;
                    end else if (m_q1.size() > 0) begin
                        owner = 1; busy = 1; seen = 0;
                    end
                end
                if (bus.in_wr_0 === 1'b1) m_q0.push_back({bus.in_ctrl_0, bus.in_data_0});
                if (bus.in_wr_1 === 1'b1) m_q1.push_back({bus.in_ctrl_1, bus.in_data_1});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1;
        tx0.delete(); tx1.delete();
        rdy_mode = 0;
        @(posedge clk); #2;
        reset = 0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((tx0.size() > 0 || tx1.size() > 0 || m_q0.size() > 0 ||
                m_q1.size() > 0 || busy) && n < max_cycles) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d cycles limit %0d", n, max_cycles);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        reset = 1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bus.out_wr !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_wr: got %0b expected 0", bus.out_wr);
        end
        checks++;
        if (bus.in_rdy_0 !== 1'b1 || bus.in_rdy_1 !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_rdy: got %0b%0b expected 11", bus.in_rdy_1, bus.in_rdy_0);
        end
        checks++;
        if (bus.pkt_cnt_0 !== 32'd0 || bus.pkt_cnt_1 !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_pkt_cnt: got %0h/%0h expected 0/0", bus.pkt_cnt_0, bus.pkt_cnt_1);
        end
        reset = 0;
    endtask

    task automatic test_single_port();
        int base;
        int n;
        do_reset();
        base = out_words;
        push_tx(0, mk(8'hFF));
        repeat (3) push_tx(0, mk(8'h00));
        push_tx(0, mk(8'h01));
        n = 0;
        do begin @(negedge clk); n++; end while (bus.in_wr_0 !== 1'b1 && n < 20);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_wr !== 1'b1 && n < 20);
        checks++;
        if (n != 2) begin
            errors++; $display("[TB] FAIL first_word_latency: got %0d cycles expected 2", n);
        end
        wait_drain(200);
        checks++;
        if (out_words - base != 5) begin
            errors++; $display("[TB] FAIL single_word_count: got %0d expected 5", out_words - base);
        end
        checks++;
        if (bus.pkt_cnt_0 !== 32'd1 || bus.pkt_cnt_1 !== 32'd0) begin
            errors++; $display("[TB] FAIL single_pkt_cnt: got %0h/%0h expected 1/0", bus.pkt_cnt_0, bus.pkt_cnt_1);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        pkt_order.delete();
        make_pkt(0, 1, 3);
        make_pkt(1, 1, 3);
        wait_drain(200);
        make_pkt(0, 1, 2);
        make_pkt(1, 1, 2);
        wait_drain(200);
        checks++;
        if (pkt_order.size() != 4) begin
            errors++; $display("[TB] FAIL rr_pkt_total: got %0d expected 4", pkt_order.size());
        end else begin
            checks++;
            if (pkt_order[0] != 0 || pkt_order[1] != 1 || pkt_order[2] != 0 || pkt_order[3] != 1) begin
                errors++;
                $display("[TB] FAIL rr_order: got %0d%0d%0d%0d expected 0101",
                         pkt_order[0], pkt_order[1], pkt_order[2], pkt_order[3]);
            end
        end
    endtask

    task automatic test_stall();
        int base;
        do_reset();
        base = out_words;
        rdy_mode = 2;
        make_pkt(0, 1, 6);
        wait_drain(300);
        rdy_mode = 0;
        checks++;
        if (out_words - base != 8) begin
            errors++; $display("[TB] FAIL stall_word_count: got %0d expected 8", out_words - base);
        end
        checks++;
        if (bus.pkt_cnt_0 !== 32'd1) begin
            errors++; $display("[TB] FAIL stall_pkt_cnt: got %0h expected 1", bus.pkt_cnt_0);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit saw_low = 0;
        do_reset();
        base = out_words;
        rdy_mode = 1;
        repeat (3) make_pkt(1, 1, 6);
        repeat (10) begin
            @(negedge clk);
            if (bus.in_rdy_1 === 1'b0) saw_low = 1;
        end
        rdy_mode = 0;
        wait_drain(500);
        checks++;
        if (!saw_low) begin
            errors++; $display("[TB] FAIL backpressure_rdy_low: got 0 expected 1");
        end
        checks++;
        if (bus.in_rdy_1 !== 1'b1) begin
            errors++; $display("[TB] FAIL backpressure_rdy_recover: got %0b expected 1", bus.in_rdy_1);
        end
        checks++;
        if (out_words - base != 24 || bus.pkt_cnt_1 !== 32'd3) begin
            errors++;
            $display("[TB] FAIL backpressure_totals: got %0d words %0h pkts expected 24 words 3 pkts",
                     out_words - base, bus.pkt_cnt_1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int n = 0;
        do_reset();
        base = out_words;
        make_pkt(0, 1, 3);
        while (out_words - base < 2 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #2;
        reset = 1;
        tx0.delete();
        @(negedge clk);
        checks++;
        if (bus.out_wr !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_out_wr: got %0b expected 0", bus.out_wr);
        end
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        checks++;
        if (bus.pkt_cnt_0 !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_pkt_cnt: got %0h expected 0", bus.pkt_cnt_0);
        end
        #1;
        base = out_words;
        make_pkt(0, 1, 3);
        wait_drain(200);
        checks++;
        if (out_words - base != 5 || bus.pkt_cnt_0 !== 32'd1) begin
            errors++;
            $display("[TB] FAIL midreset_next_pkt: got %0d words %0h pkts expected 5 words 1 pkt",
                     out_words - base, bus.pkt_cnt_0);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        @(negedge clk); #2;
        force dut.cnt_1 = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_1;
        m_cnt1 = 32'hFFFF_FFFF;
        make_pkt(1, 1, 1);
        wait_drain(200);
        checks++;
        if (bus.pkt_cnt_1 !== 32'd0 || bus.pkt_cnt_0 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL counter_wrap: got %0h/%0h expected 0/0", bus.pkt_cnt_0, bus.pkt_cnt_1);
        end
    endtask

    task automatic test_random();
        logic [31:0] base0, base1;
        int n0 = 0, n1 = 0;
        bit p;
        base0 = bus.pkt_cnt_0;
        base1 = bus.pkt_cnt_1;
        rdy_mode = 3;
        for (int i = 0; i < 40; i++) begin
            p = 1'($urandom_range(0, 1));
            make_pkt(p, $urandom_range(1, 2), $urandom_range(1, 5));
            if (p) n1++; else n0++;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
        end
        wait_drain(5000);
        rdy_mode = 0;
        checks++;
        if (bus.pkt_cnt_0 - base0 !== 32'(n0) || bus.pkt_cnt_1 - base1 !== 32'(n1)) begin
            errors++;
            $display("[TB] FAIL random_pkt_totals: got %0d/%0d expected %0d/%0d",
                     bus.pkt_cnt_0 - base0, bus.pkt_cnt_1 - base1, n0, n1);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
